// File: rtl/vga_rect_scheduler_if.sv
// Bundle between the rectangle requesters and the plot-port scheduler.
// Request side: req, req_x/y/w/h/color (packed, requester i in slice i).
// Response side: ack, done, busy, and the VGA adapter plot port.
// The slave modport is the scheduler; the master modport is the requester side.
interface vga_rect_scheduler_if #(
    parameter int N = 3
);
    logic [N-1:0]   req;
    logic [8*N-1:0] req_x;
    logic [7*N-1:0] req_y;
    logic [8*N-1:0] req_w;
    logic [7*N-1:0] req_h;
    logic [3*N-1:0] req_color;
    logic [N-1:0]   ack;
    logic [N-1:0]   done;
    logic           busy;
    logic [7:0]     VGA_X;
    logic [6:0]     VGA_Y;
    logic [2:0]     VGA_COLOR;
    logic           plot;

    modport slave (
        input  req, req_x, req_y, req_w, req_h, req_color,
        output ack, done, busy, VGA_X, VGA_Y, VGA_COLOR, plot
    );

    modport master (
        output req, req_x, req_y, req_w, req_h, req_color,
        input  ack, done, busy, VGA_X, VGA_Y, VGA_COLOR, plot
    );
endinterface

// File: rtl/vga_rect_scheduler.sv
// Round-robin scheduler sharing one 160x120 VGA plot port between N
// rectangle-fill requesters. A granted rectangle is scanned one pixel per
// clock in raster order; off-screen pixels cost a cycle but are not plotted.
// Ports: CLOCK_50 (clock), resetn (async active-low), bus (slave modport:
// requests in, ack/done/busy and VGA_X/VGA_Y/VGA_COLOR/plot out).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for any request; arbitrates on each edge
// S_DRAW   | presenting pixel (col_q,row_q) of the granted rectangle
// S_EMPTY  | ack cycle of a zero-area rectangle, nothing is plotted
// S_DONE   | done pulse to the granted requester, then back to idle
module vga_rect_scheduler #(
    parameter int N     = 3,
    parameter int X_MAX = 159,
    parameter int Y_MAX = 119
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    vga_rect_scheduler_if.slave  bus
);
    localparam int PW = (N > 1) ? $clog2(N) : 1;
    localparam logic [8:0] XLIM = 9'(X_MAX);
    localparam logic [7:0] YLIM = 8'(Y_MAX);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DRAW  = 2'd1;
    localparam logic [1:0] S_EMPTY = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic [PW-1:0] g_q, g_d;
    logic [7:0]    x0_q, x0_d, w_q, w_d, col_q, col_d;
    logic [6:0]    y0_q, y0_d, h_q, h_d, row_q, row_d;
    logic [N-1:0]  ack_q, ack_d, done_q, done_d;
    logic          busy_q, busy_d, plot_q, plot_d;
    logic [7:0]    vx_q, vx_d;
    logic [6:0]    vy_q, vy_d;
    logic [2:0]    color_q, color_d;

    // Arbitration: first set request at or after the pointer, wrapping.
    logic          found;
    logic [PW-1:0] gnt;
    always_comb begin
        int k;
        found = 1'b0;
        gnt   = '0;
        k     = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(ptr_q) + i;
            if (k >= N) k = k - N;
            if (!found && bus.req[k]) begin
                found = 1'b1;
                gnt   = PW'(k);
            end
        end
    end

    logic [7:0] f_x, f_w;
    logic [6:0] f_y, f_h;
    logic [2:0] f_c;
    assign f_x = bus.req_x[8*int'(gnt) +: 8];
    assign f_y = bus.req_y[7*int'(gnt) +: 7];
    assign f_w = bus.req_w[8*int'(gnt) +: 8];
    assign f_h = bus.req_h[7*int'(gnt) +: 7];
    assign f_c = bus.req_color[3*int'(gnt) +: 3];

    // Next scan position inside the current rectangle.
    logic       row_end, last;
    logic [7:0] col_nxt;
    logic [6:0] row_nxt;
    assign row_end = (col_q == w_q - 8'd1);
    assign last    = row_end && (row_q == h_q - 7'd1);
    assign col_nxt = row_end ? 8'd0 : col_q + 8'd1;
    assign row_nxt = row_end ? row_q + 7'd1 : row_q;

    // Screen coordinates are formed one bit wider so clipping sees overflow.
    logic [8:0] sx;
    logic [7:0] sy;
    always_comb begin
        if (state_q == S_IDLE) begin
            sx = {1'b0, f_x};
            sy = {1'b0, f_y};
        end else begin
            sx = {1'b0, x0_q} + {1'b0, col_nxt};
            sy = {1'b0, y0_q} + {1'b0, row_nxt};
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        g_d     = g_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        w_d     = w_q;
        h_d     = h_q;
        col_d   = col_q;
        row_d   = row_q;
        ack_d   = '0;
        done_d  = '0;
        busy_d  = busy_q;
        plot_d  = 1'b0;
        vx_d    = vx_q;
        vy_d    = vy_q;
        color_d = color_q;
        case (state_q)
            S_IDLE: begin
                if (found) begin
                    ack_d   = N'(1) << gnt;
                    busy_d  = 1'b1;
                    g_d     = gnt;
                    ptr_d   = (gnt == PW'(N - 1)) ? '0 : gnt + PW'(1);
                    x0_d    = f_x;
                    y0_d    = f_y;
                    w_d     = f_w;
                    h_d     = f_h;
                    color_d = f_c;
                    col_d   = '0;
                    row_d   = '0;
                    if (f_w == 8'd0 || f_h == 7'd0) begin
                        state_d = S_EMPTY;
                    end else begin
                        state_d = S_DRAW;
                        vx_d    = sx[7:0];
                        vy_d    = sy[6:0];
                        plot_d  = (sx <= XLIM) && (sy <= YLIM);
                    end
                end
            end
            S_DRAW: begin
                if (last) begin
                    state_d = S_DONE;
                    done_d  = N'(1) << g_q;
                end else begin
                    col_d  = col_nxt;
                    row_d  = row_nxt;
                    vx_d   = sx[7:0];
                    vy_d   = sy[6:0];
                    plot_d = (sx <= XLIM) && (sy <= YLIM);
                end
            end
            S_EMPTY: begin
                state_d = S_DONE;
                done_d  = N'(1) << g_q;
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            g_q     <= '0;
            x0_q    <= '0;
            y0_q    <= '0;
            w_q     <= '0;
            h_q     <= '0;
            col_q   <= '0;
            row_q   <= '0;
            ack_q   <= '0;
            done_q  <= '0;
            busy_q  <= 1'b0;
            plot_q  <= 1'b0;
            vx_q    <= '0;
            vy_q    <= '0;
            color_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            g_q     <= g_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            w_q     <= w_d;
            h_q     <= h_d;
            col_q   <= col_d;
            row_q   <= row_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            plot_q  <= plot_d;
            vx_q    <= vx_d;
            vy_q    <= vy_d;
            color_q <= color_d;
        end
    end

    assign bus.ack       = ack_q;
    assign bus.done      = done_q;
    assign bus.busy      = busy_q;
    assign bus.plot      = plot_q;
    assign bus.VGA_X     = vx_q;
    assign bus.VGA_Y     = vy_q;
    assign bus.VGA_COLOR = color_q;
endmodule

// File: tb/tb_vga_rect_scheduler.sv
module tb_vga_rect_scheduler;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;

    always #5 clk = ~clk;

    vga_rect_scheduler_if #(.N(3)) bus ();

    vga_rect_scheduler #(.N(3), .X_MAX(159), .Y_MAX(119)) dut (
        .CLOCK_50 (clk),
        .resetn   (rst_n),
        .bus      (bus.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic set_req(input int i, input logic [7:0] x, input logic [6:0] y,
                           input logic [7:0] w, input logic [6:0] h, input logic [2:0] c);
        bus.req_x[8*i +: 8]     = x;
        bus.req_y[7*i +: 7]     = y;
        bus.req_w[8*i +: 8]     = w;
        bus.req_h[7*i +: 7]     = h;
        bus.req_color[3*i +: 3] = c;
    endtask

    task automatic chk_pix(input string tag, input int x, input int y, input logic p);
        chk({tag, "_x"}, 32'(bus.VGA_X), 32'(x));
        chk({tag, "_y"}, 32'(bus.VGA_Y), 32'(y));
        chk({tag, "_plot"}, 32'(bus.plot), 32'(p));
    endtask

    int ex1 [6] = '{10, 11, 12, 10, 11, 12};
    int ey1 [6] = '{20, 20, 20, 21, 21, 21};
    int exc [8] = '{158, 159, 160, 161, 158, 159, 160, 161};
    int eyc [8] = '{119, 119, 119, 119, 120, 120, 120, 120};
    int epc [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
    int rr_order [4] = '{0, 1, 2, 0};
    int rr_x [3] = '{1, 2, 3};

    initial begin
        bus.req       = '0;
        bus.req_x     = '0;
        bus.req_y     = '0;
        bus.req_w     = '0;
        bus.req_h     = '0;
        bus.req_color = '0;

        // reset state
        tick();
        tick();
        chk("rst_ack", 32'(bus.ack), 0);
        chk("rst_done", 32'(bus.done), 0);
        chk("rst_busy", 32'(bus.busy), 0);
        chk_pix("rst", 0, 0, 1'b0);
        chk("rst_color", 32'(bus.VGA_COLOR), 0);
        rst_n = 1'b1;
        tick();

        // single request 3x2 at (10,20), colour 4
        set_req(0, 8'd10, 7'd20, 8'd3, 7'd2, 3'b100);
        bus.req = 3'b001;
        tick();
        chk("s_ack", 32'(bus.ack), 1);
        bus.req = 3'b000;
        for (int i = 0; i < 6; i++) begin
            chk_pix("s_pix", ex1[i], ey1[i], 1'b1);
            chk("s_color", 32'(bus.VGA_COLOR), 4);
            chk("s_busy", 32'(bus.busy), 1);
            chk("s_done_low", 32'(bus.done), 0);
            if (i > 0) chk("s_ack_low", 32'(bus.ack), 0);
            tick();
        end
        chk("s_done", 32'(bus.done), 1);
        chk("s_done_plot", 32'(bus.plot), 0);
        chk("s_done_busy", 32'(bus.busy), 1);
        tick();
        chk("s_idle_done", 32'(bus.done), 0);
        chk("s_idle_busy", 32'(bus.busy), 0);

        // round robin from a fresh pointer
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) set_req(i, 8'(rr_x[i]), 7'd5, 8'd1, 7'd1, 3'(i + 1));
        bus.req = 3'b111;
        tick();
        for (int n = 0; n < 4; n++) begin
            chk("rr_ack", 32'(bus.ack), 32'(1 << rr_order[n]));
            chk_pix("rr_pix", rr_x[rr_order[n]], 5, 1'b1);
            tick();
            chk("rr_done", 32'(bus.done), 32'(1 << rr_order[n]));
            chk("rr_done_plot", 32'(bus.plot), 0);
            tick();
            chk("rr_gap_plot", 32'(bus.plot), 0);
            chk("rr_gap_ack", 32'(bus.ack), 0);
            chk("rr_gap_busy", 32'(bus.busy), 0);
            if (n < 3) tick();
        end
        bus.req = 3'b000;
        tick();

        // clipping at the bottom-right corner (pointer now at requester 1)
        set_req(1, 8'd158, 7'd119, 8'd4, 7'd2, 3'b010);
        bus.req = 3'b010;
        tick();
        chk("c_ack", 32'(bus.ack), 2);
        bus.req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            chk_pix("c_pix", exc[i], eyc[i], epc[i][0]);
            chk("c_done_low", 32'(bus.done), 0);
            tick();
        end
        chk("c_done", 32'(bus.done), 2);
        chk("c_done_plot", 32'(bus.plot), 0);
        tick();

        // zero-area rectangle (pointer at requester 2)
        set_req(2, 8'd30, 7'd30, 8'd0, 7'd5, 3'b111);
        bus.req = 3'b100;
        tick();
        chk("z_ack", 32'(bus.ack), 4);
        chk("z_ack_plot", 32'(bus.plot), 0);
        chk("z_busy", 32'(bus.busy), 1);
        bus.req = 3'b000;
        tick();
        chk("z_done", 32'(bus.done), 4);
        chk("z_done_plot", 32'(bus.plot), 0);
        tick();
        chk("z_idle_busy", 32'(bus.busy), 0);
        chk("z_idle_plot", 32'(bus.plot), 0);

        // request withdrawn before it could be granted
        set_req(0, 8'd0, 7'd0, 8'd2, 7'd2, 3'b001);
        set_req(2, 8'd50, 7'd50, 8'd1, 7'd1, 3'b011);
        bus.req = 3'b001;
        tick();
        chk("w_ack0", 32'(bus.ack), 1);
        bus.req = 3'b100;
        tick();
        bus.req = 3'b000;
        for (int i = 0; i < 8; i++) begin
            chk("w_no_ack2", 32'(bus.ack[2]), 0);
            chk("w_no_done2", 32'(bus.done[2]), 0);
            if (i == 3) chk("w_done0", 32'(bus.done), 1);
            tick();
        end

        // reset during pixel 3 of a 4x4 fill
        set_req(0, 8'd5, 7'd5, 8'd4, 7'd4, 3'b110);
        bus.req = 3'b001;
        tick();
        chk("r_ack", 32'(bus.ack), 1);
        bus.req = 3'b000;
        tick();
        tick();
        chk_pix("r_pix3", 7, 5, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("r_async_busy", 32'(bus.busy), 0);
        chk_pix("r_async", 0, 0, 1'b0);
        chk("r_async_color", 32'(bus.VGA_COLOR), 0);
        set_req(1, 8'd30, 7'd40, 8'd1, 7'd1, 3'b101);
        bus.req = 3'b010;
        tick();
        chk("r_hold_ack", 32'(bus.ack), 0);
        chk("r_hold_done", 32'(bus.done), 0);
        rst_n = 1'b1;
        tick();
        chk("r_gnt1", 32'(bus.ack), 2);
        chk("r_no_done", 32'(bus.done), 0);
        chk_pix("r_gnt_pix", 30, 40, 1'b1);
        bus.req = 3'b000;
        tick();
        chk("r_done1", 32'(bus.done), 2);
        tick();

        // pointer now past requester 1: requesters 0 and 2 compete, 2 wins
        set_req(0, 8'd1, 7'd1, 8'd1, 7'd1, 3'b001);
        set_req(2, 8'd2, 7'd2, 8'd1, 7'd1, 3'b010);
        bus.req = 3'b101;
        tick();
        chk("p_gnt2", 32'(bus.ack), 4);
        bus.req = 3'b001;
        tick();
        tick();
        tick();
        chk("p_gnt0", 32'(bus.ack), 1);
        bus.req = 3'b000;
        tick();
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/vga_rect_scheduler.md
Name: vga_rect_scheduler

Overview:
- Shares the single VGA adapter plot port (VGA_X, VGA_Y, VGA_COLOR, plot) between N rectangle-fill requesters: background clear, falling-tile drawer, score/hit-feedback painter.
- Round-robin arbitration; a granted rectangle is rasterised one pixel per clock.
- Sits between the game logic and the 160x120 VGA adapter inside display.

Parameters:
- N, 3, number of requesters.
- X_MAX, 159, last visible column; pixels beyond it are not plotted.
- Y_MAX, 119, last visible row; pixels beyond it are not plotted.

Ports:
- CLOCK_50  in  1  system clock; all state changes on its rising edge.
- resetn  in  1  asynchronous, active-low reset.
- req  in  N  per-requester draw request; held high until its ack.
- req_x  in  8*N  rectangle left column; requester i uses bits [8i+7:8i].
- req_y  in  7*N  rectangle top row; packed the same way.
- req_w  in  8*N  width in pixels (0..255).
- req_h  in  7*N  height in pixels (0..127).
- req_color  in  3*N  fill colour.
- ack  out  N  one-cycle grant pulse; parameters are sampled on the edge that raises it.
- done  out  N  one-cycle completion pulse to the granted requester.
- busy  out  1  high from the ack cycle through the done cycle, inclusive.
- VGA_X  out  8  pixel column.
- VGA_Y  out  7  pixel row.
- VGA_COLOR  out  3  pixel colour.
- plot  out  1  write strobe to the adapter.

Behaviour:
- All outputs are registered.
- Reset values: ack=0, done=0, busy=0, VGA_X=0, VGA_Y=0, VGA_COLOR=0, plot=0, state=IDLE, round-robin pointer=0.
- State IDLE:
  - Clock edge with any req bit high: grant the first set bit at or after the pointer (wrapping).
  - ack[g]=1 for exactly the next cycle; latch x0, y0, w, h, colour; pointer <= (g+1) mod N.
  - If w=0 or h=0: go to DONE; plot stays 0.
  - Otherwise go to DRAW; the first pixel (x0,y0) is presented in the same cycle as ack.
- State DRAW: one pixel per cycle in raster order (col 0..w-1 inside row 0..h-1).
  - VGA_X = x0+col and VGA_Y = y0+row, both computed 1 bit wider.
  - plot=1 only if x0+col <= X_MAX and y0+row <= Y_MAX; otherwise plot=0 and the scan still advances (clipping costs cycles but writes nothing).
  - Clipped cycles drive VGA_X/VGA_Y with the truncated value.
  - Exactly w*h DRAW cycles.
- State DONE: one cycle with plot=0, done[g]=1, busy=1; then IDLE.
- IDLE samples on the edge after DONE. Back-to-back rectangles therefore have a 2-cycle gap:
  - L = last pixel
  - L+1 = done
  - L+2 = IDLE sample (plot=0)
  - L+3 = next ack and first pixel.
- A req held high past its done is re-arbitrated like a new request. The round-robin pointer prevents starvation.
- req dropped before ack: nothing is drawn, no ack, no done.
- Changes to req_* after ack have no effect on the current rectangle.
- Simultaneous requests: only one ack per grant; the others wait, holding req.
- resetn low mid-rectangle: immediately abort. Outputs take their reset values, no done for the aborted rectangle, pointer returns to 0.
- plot never asserts outside DRAW.

Test Plan:
- Single request: req[0], (x,y)=(10,20), w=3, h=2, colour 3'b100, sampled at edge k.
  - Cycles k+1..k+6 show (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), plot=1, VGA_COLOR=4.
  - ack[0] high only in k+1; done[0] only in k+7; busy high k+1..k+7.
- Round-robin: req=3'b111, each w=1, h=1, all held.
  - Grants go 0,1,2,0 with done pulses spaced 3 cycles apart.
  - plot is 0 in every gap cycle.
- Clipping: x=158, y=119, w=4, h=2.
  - 8 DRAW cycles; plot=1 only for (158,119) and (159,119); no writes at row 120.
  - done arrives after the 8th DRAW cycle.
- Zero size: w=0, h=5.
  - ack then done the next cycle; plot stays 0 throughout.
- Reset mid-draw: resetn low during pixel 3 of a 4x4 fill.
  - Outputs 0 asynchronously; no done pulse.
  - After release with req[1] high, req[1] is granted on the first IDLE edge; pointer is 0 and req[0] is low.
- Request withdrawn: req[2] pulsed high for one cycle while busy with requester 0.
  - No ack[2], no done[2] at any point.
